pipeline_control: RTL
=====================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4, number of clock-enabled cycles needed to retire in-flight instructions after a halt instruction is decoded.
REQ-002 clock  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  one-cycle strobe; cmd is sampled when high.
REQ-005 cmd  in  2  00 nop, 01 run, 10 step, 11 halt (from UART debug unit).
REQ-006 id_rs, id_rt  in  5 each  source register fields of the instruction in ID (instruc[25:21], instruc[20:16]).
REQ-007 ex_mem_read  in  1  instruction in EX is a load.
REQ-008 ex_rt  in  5  destination register of the load in EX.
REQ-009 branch_sel, jump_sel  in  1 each  taken-branch / jump indications from the decode stage.
REQ-010 halt_instr  in  1  instruction in ID is the halt opcode.
REQ-011 pipe_en  out  1  global clock enable for all pipeline registers, PC and register bank writes.
REQ-012 pc_write, if_id_write  out  1 each  PC and IF/ID register load enables.
REQ-013 if_id_flush  out  1  clears IF/ID to a nop on next enabled edge.
REQ-014 mux_ctrl_signal_sel  out  1  1 passes decoded control, 0 inserts bubble (all-zero control).
REQ-015 state  out  2  HALT=00, RUN=01, STEP=10, DRAIN=11.
REQ-016 cycle_count  out  32  number of enabled cycles since reset.

Function
REQ-017 FSM SHALL have states HALT, RUN, STEP, DRAIN; pipe_en SHALL be 1 in RUN, STEP and DRAIN, 0 in HALT.
REQ-018 HALT: cmd run -> RUN; cmd step -> STEP; other cmds ignored.
REQ-019 STEP SHALL last exactly one cycle, then return to HALT unconditionally (one enabled cycle per step command).
REQ-020 RUN: cmd halt -> HALT immediately; halt_instr=1 with pipe_en=1 and no stall -> DRAIN; otherwise remain.
REQ-021 DRAIN SHALL load a 3-bit-or-wider down-counter with DRAIN_CYCLES-1 on entry, decrement each cycle, and go to HALT the cycle after it reads 0; cmd halt in DRAIN -> HALT immediately; cmd run/step ignored.
REQ-022 During DRAIN, pc_write and if_id_write SHALL be 0 and mux_ctrl_signal_sel 0 (no new instructions admitted); remaining stages advance.
REQ-023 Load-use stall (combinational) = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-024 In RUN/STEP with stall: pc_write=0, if_id_write=0, mux_ctrl_signal_sel=0, if_id_flush=0.
REQ-025 In RUN/STEP without stall: pc_write=1, if_id_write=1, mux_ctrl_signal_sel=1, if_id_flush = branch_sel | jump_sel.
REQ-026 Stall SHALL take priority over branch/jump flush in the same cycle.
REQ-027 In HALT all of pc_write, if_id_write, if_id_flush, mux_ctrl_signal_sel SHALL be 0.
REQ-028 cmd_valid with cmd halt SHALL win over any simultaneous halt_instr transition.
REQ-029 cycle_count SHALL increment by 1 on each edge where pipe_en=1, wrap from 0xFFFFFFFF to 0.
REQ-030 All outputs SHALL be combinational functions of registered state and current inputs; no added latency.

Reset
REQ-031 reset low SHALL asynchronously force state=HALT, drain counter=0, cycle_count=0; hence pipe_en=0, pc_write=0, if_id_write=0, if_id_flush=0, mux_ctrl_signal_sel=0.
REQ-032 Reset asserted mid-DRAIN or mid-STEP SHALL abort the operation; after release the block waits in HALT for a command.

Verification
REQ-033 Reset, then cmd step x3 with gaps -> exactly 3 cycles with pipe_en=1, cycle_count=3, state=00 after each.
REQ-034 RUN, ex_mem_read=1, ex_rt=5, id_rs=5 -> pc_write=0, if_id_write=0, mux_ctrl_signal_sel=0, pipe_en=1; ex_rt=0 same case -> no stall.
REQ-035 RUN, branch_sel=1 with stall active -> if_id_flush=0; stall removed next cycle -> if_id_flush=1.
REQ-036 RUN, halt_instr=1 -> DRAIN for exactly 4 enabled cycles (DRAIN_CYCLES=4) with pc_write=0, then HALT, pipe_en=0.
REQ-037 RUN, cmd halt coinciding with halt_instr -> state=HALT next cycle, DRAIN never entered.
REQ-038 Assert reset during DRAIN at cycle 2 -> all outputs 0 immediately, cycle_count=0, state=00.

Source files
------------

// File: rtl/pipeline_control.sv
// Pipeline run/step/halt controller: debug-command FSM, load-use stall detection,
// branch/jump flush and enabled-cycle counter for a 5-stage pipeline.
module pipeline_control #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    input  logic [1:0]  i_cmd,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_rt,
    input  logic        i_branch_sel,
    input  logic        i_jump_sel,
    input  logic        i_halt_instr,
    output logic        o_pipe_en,
    output logic        o_pc_write,
    output logic        o_if_id_write,
    output logic        o_if_id_flush,
    output logic        o_mux_ctrl_signal_sel,
    output logic [1:0]  o_state,
    output logic [31:0] o_cycle_count
);

    localparam int CNT_W = (DRAIN_CYCLES > 8) ? $clog2(DRAIN_CYCLES) : 3;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic [31:0]       r_cycle_count;
    logic              w_stall;
    logic              w_cmd_run;
    logic              w_cmd_step;
    logic              w_cmd_halt;

    assign w_cmd_run  = i_cmd_valid && (i_cmd == CMD_RUN);
    assign w_cmd_step = i_cmd_valid && (i_cmd == CMD_STEP);
    assign w_cmd_halt = i_cmd_valid && (i_cmd == CMD_HALT);

    assign w_stall = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                     ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

    // Debug halt is checked first so it beats a halt_instr decoded in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (w_cmd_run)       w_next = ST_RUN;
                else if (w_cmd_step) w_next = ST_STEP;
            end
            ST_RUN: begin
                if (w_cmd_halt)                     w_next = ST_HALT;
                else if (i_halt_instr && !w_stall)  w_next = ST_DRAIN;
            end
            ST_STEP:  w_next = ST_HALT;
            ST_DRAIN: begin
                if (w_cmd_halt || (r_drain_cnt == '0)) w_next = ST_HALT;
            end
            default:  w_next = ST_HALT;
        endcase
    end

    always_comb begin
        o_pipe_en             = (r_state != ST_HALT);
        o_pc_write            = 1'b0;
        o_if_id_write         = 1'b0;
        o_if_id_flush         = 1'b0;
        o_mux_ctrl_signal_sel = 1'b0;
        if (((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_stall) begin
            o_pc_write            = 1'b1;
            o_if_id_write         = 1'b1;
            o_if_id_flush         = i_branch_sel | i_jump_sel;
            o_mux_ctrl_signal_sel = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_next;
        end
    end

    // Loaded on DRAIN entry so DRAIN lasts exactly DRAIN_CYCLES enabled cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drain_cnt <= '0;
        end else if ((r_state != ST_DRAIN) && (w_next == ST_DRAIN)) begin
            r_drain_cnt <= DRAIN_LOAD;
        end else if (w_next != ST_DRAIN) begin
            r_drain_cnt <= '0;
        end else if (r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_count <= '0;
        end else if (o_pipe_en) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign o_state       = r_state;
    assign o_cycle_count = r_cycle_count;

endmodule
